// File: rtl/axi4lite_pkg.sv
// Response codes and sizing helper shared by the AXI4-Lite parameter RAM.
package axi4lite_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;

  // Word-index width; never less than one bit so tiny memories still elaborate.
  function automatic int idx_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/axi4lite_ram_mem.sv
// Byte-enabled single-write/single-read synchronous RAM, read-first, one-cycle read latency.
module axi4lite_ram_mem
  import axi4lite_pkg::*;
#(
  parameter  int DATA_WIDTH  = 32,
  parameter  int DEPTH_WORDS = 1024,
  localparam int IW          = idx_width(DEPTH_WORDS),
  localparam int NB          = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [IW-1:0]         i_waddr,
  input  logic [NB-1:0]         i_wbe,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [IW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  // Contents are deliberately not reset; a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < NB; i++) begin
        if (i_wbe[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/axi4lite_param_ram.sv
// AXI4-Lite slave scratch RAM with byte strobes, independent AW/W buffering and SLVERR on range misses.
// Define AXI4LITE_RAM_PROT_EN to reject unprivileged (prot[0]=0) accesses with SLVERR.
module axi4lite_param_ram
  import axi4lite_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [2:0]              awprot,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic                    bvalid,
  output logic [1:0]              bresp,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [2:0]              arprot,
  input  logic                    arvalid,
  output logic                    arready,
  output logic                    rvalid,
  output logic [1:0]              rresp,
  output logic [DATA_WIDTH-1:0]   rdata,
  input  logic                    rready
);

  localparam int          NB      = DATA_WIDTH / 8;
  localparam int          IW      = idx_width(DEPTH_WORDS);
  localparam int          BSHIFT  = $clog2(NB);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);

  logic                  r_aw_full, r_w_full, r_bvalid, r_rvalid, r_rd_ok;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic [NB-1:0]         r_w_strb;
  axi_resp_t             r_bresp, r_rresp;

  logic [ADDR_WIDTH-1:0] w_aw_idx, w_ar_idx;
  logic                  w_aw_ok, w_ar_ok, w_commit, w_ar_hs;
  logic [DATA_WIDTH-1:0] w_mem_rdata;

  assign w_aw_idx = r_aw_addr >> BSHIFT;
  assign w_ar_idx = araddr >> BSHIFT;

`ifdef AXI4LITE_RAM_PROT_EN
  logic r_aw_priv;
  logic w_unused_prot;

  assign w_aw_ok       = (32'(w_aw_idx) < DEPTH_U) && r_aw_priv;
  assign w_ar_ok       = (32'(w_ar_idx) < DEPTH_U) && arprot[0];
  assign w_unused_prot = ^{awprot[2:1], arprot[2:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_aw_priv <= 1'b0;
    else if (awvalid && !r_aw_full)  r_aw_priv <= awprot[0];
  end
`else
  logic w_unused_prot;

  assign w_aw_ok       = (32'(w_aw_idx) < DEPTH_U);
  assign w_ar_ok       = (32'(w_ar_idx) < DEPTH_U);
  assign w_unused_prot = ^{awprot, arprot};
`endif

  // A pending unaccepted B response blocks the next commit, keeping both buffers full.
  assign w_commit = r_aw_full && r_w_full && (!r_bvalid || bready);
  assign w_ar_hs  = arvalid && arready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_full <= 1'b0;
      r_aw_addr <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if (awvalid && !r_aw_full) begin
        r_aw_full <= 1'b1;
        r_aw_addr <= awaddr;
      end else if (w_commit) begin
        r_aw_full <= 1'b0;
      end
      if (wvalid && !r_w_full) begin
        r_w_full <= 1'b1;
        r_w_data <= wdata;
        r_w_strb <= wstrb;
      end else if (w_commit) begin
        r_w_full <= 1'b0;
      end
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_aw_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rd_ok  <= 1'b0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rd_ok  <= w_ar_ok;
      r_rresp  <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (rready) begin
      r_rvalid <= 1'b0;
    end
  end

  axi4lite_ram_mem #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_commit && w_aw_ok),
    .i_waddr (w_aw_idx[IW-1:0]),
    .i_wbe   (r_w_strb),
    .i_wdata (r_w_data),
    .i_re    (w_ar_hs && w_ar_ok),
    .i_raddr (w_ar_idx[IW-1:0]),
    .o_rdata (w_mem_rdata)
  );

  assign awready = !r_aw_full;
  assign wready  = !r_w_full;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign arready = !r_rvalid || rready;
  assign rvalid  = r_rvalid;
  assign rresp   = r_rresp;
  // Holding the masked memory output keeps rdata zero after reset and for rejected reads.
  assign rdata   = r_rd_ok ? w_mem_rdata : '0;

endmodule

// File: doc/axi4lite_param_ram.md
# axi4lite_param_ram

Parametrised AXI4-Lite slave RAM, the next generation of the team's single-port AXI4-Lite memory. Generalised in data width and depth. Honours byte strobes. Accepts write address and write data independently, in either order. Returns SLVERR for out-of-range accesses. Sits on the peripheral interconnect as a scratch/mailbox memory.

## Interface
- ADDR_WIDTH, 16, byte address width of awaddr/araddr
- DATA_WIDTH, 32, data bus width; legal values 32 or 64
- DEPTH_WORDS, 1024, number of DATA_WIDTH words; DEPTH_WORDS*(DATA_WIDTH/8) <= 2^ADDR_WIDTH
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- awaddr / awprot / awvalid  in  ADDR_WIDTH / 3 / 1  write address channel
- awready  out  1  write address buffer empty
- wdata / wstrb / wvalid  in  DATA_WIDTH / DATA_WIDTH/8 / 1  write data channel
- wready  out  1  write data buffer empty
- bvalid / bresp  out  1 / 2  write response
- bready  in  1  master accepts write response
- araddr / arprot / arvalid  in  ADDR_WIDTH / 3 / 1  read address channel
- arready  out  1  read address accepted
- rvalid / rresp / rdata  out  1 / 2 / DATA_WIDTH  read response
- rready  in  1  master accepts read response

## Operation
- Reset values: awready=1, wready=1, arready=1, bvalid=0, bresp=0, rvalid=0, rresp=0, rdata=0. Memory contents are not reset.
- Word index = addr >> log2(DATA_WIDTH/8). Low address bits are ignored (forced alignment).
- Address is in range iff word index < DEPTH_WORDS.
- Write path:
  - AW buffer (addr, prot) and W buffer (data, strb) are one entry each.
  - awready = !aw_full and wready = !w_full, both registered.
  - Commit fires when aw_full && w_full && (!bvalid || bready).
  - On commit, bytes with wstrb[i]=1 are written; bytes with wstrb[i]=0 are untouched. Both buffers clear. bvalid=1.
  - bresp = OKAY, or SLVERR with no memory change if the address is out of range.
  - bvalid holds, with bresp stable, until bready.
- Read path:
  - arready = !rvalid || rready (combinational).
  - On AR handshake the word is read; rvalid=1 next cycle.
  - In range: rresp=OKAY. Out of range: rresp=SLVERR, rdata=0.
  - rdata and rresp stay stable while rvalid && !rready.
- Same-cycle commit and read of the same word: read returns pre-write data (read-first).
- Read and write paths are fully independent; neither blocks the other.
- Asynchronous reset mid-transaction drops buffered AW/W and pending B/R responses. Any write that was not yet committed has no effect.

## Timing
- AW and W handshake in cycle N → commit at edge N+1 → bvalid high in N+2.
- AW in cycle N, W in cycle N+k → bvalid high in N+k+2.
- Write throughput: one per 2 cycles when bready=1.
- AR handshake in cycle N → rvalid in N+1.
- Read throughput: one per cycle when rready is held high.
- Backpressure:
  - bready=0 stalls commit. The buffers stay full, so awready and wready stay 0.
  - rready=0 holds arready=0.

## Configuration
- AXI4LITE_RAM_PROT_EN defined:
  - Unprivileged accesses (awprot[0]=0 or arprot[0]=0) get SLVERR.
  - Such writes change no memory; such reads return rdata=0.
- Undefined: awprot and arprot are ignored and produce no logic.

## Structure
- Package axi4lite_pkg holds:
  - resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - typedef axi_resp_t (2-bit)
  - a function computing word-index width from DEPTH_WORDS
- Sub-module axi4lite_ram_mem holds the byte-enabled synchronous memory array.
  - One write port with per-byte enables; one read port, read-first, one-cycle latency.
  - Parameters: DATA_WIDTH, DEPTH_WORDS.

## Test plan
- Aligned write/read: AW=0x0010 and W=0xDEADBEEF with strb=0xF in the same cycle, then AR=0x0010 → bresp=OKAY at +2 cycles; rdata=0xDEADBEEF, rresp=OKAY.
- Strobes: write 0x11223344 to 0x20, then write 0xAABBCCDD with strb=0x5, then read 0x20 → rdata=0x11BB33DD.
- Ordering: W presented 3 cycles before AW to 0x40 → wready drops after the W handshake; bvalid occurs 2 cycles after the AW handshake; readback is correct.
- Out of range (DEPTH_WORDS=1024, 32-bit data): write and read at 0x1000 → bresp=SLVERR, rresp=SLVERR, rdata=0; address 0x0000 is unchanged.
- Backpressure and reset: hold bready=0 and rready=0 for 5 cycles → bvalid, rvalid, rdata stay stable; awready, wready, arready stay 0. Then assert rst_n=0 mid-stall → all outputs return to reset values immediately.
- With AXI4LITE_RAM_PROT_EN: write with awprot=3'b000 → SLVERR and memory unchanged. With awprot=3'b001 → OKAY.
